mem_bus_arbiter: RTL

// - Shares the single cbus memory port between instruction fetch (ibus) and the memory stage (dbus).
// - Sits between the pipeline core and the cache/memory interface.
// - One single-beat transaction at a time: dbus has fixed priority, with a starvation guard for ibus.
// - Converts both request types to cbus_req_t and routes the cbus response back to the granted requester.

---
 rtl/common.sv | 63 ++++++
 rtl/pipes.sv | 32 +++
 rtl/streak_counter.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/common.sv
// Shared bus types for the core's memory interfaces: ibus (fetch), dbus (memory stage)
// and the cbus port towards the cache/memory side.
package common;
  typedef logic [31:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3
  } msize_t;

  // AXI-style beat count minus one
  typedef enum logic [7:0] {
    MLEN1 = 8'd0, MLEN2 = 8'd1, MLEN4 = 8'd3, MLEN8 = 8'd7, MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0, AXI_BURST_INCR = 2'd1, AXI_BURST_WRAP = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic   valid;
    addr_t  addr;
    msize_t size;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;
endpackage

// File: rtl/pipes.sv
// Arbiter state encoding and the ibus/dbus -> cbus request converters.
package pipes;
  import common::*;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

  function automatic cbus_req_t to_cbus_i(input ibus_req_t r);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = 1'b0;
    c.size     = r.size;
    c.addr     = r.addr;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

  function automatic cbus_req_t to_cbus_d(input dbus_req_t r);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = |r.strobe;
    c.size     = r.size;
    c.addr     = r.addr;
    c.strobe   = r.strobe;
    c.data     = r.data;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction
endpackage

// File: rtl/streak_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module streak_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                                count_d = '0;
    else if (inc && (count_q != W'(MAX)))   count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single cbus port between fetch (ibus) and memory stage (dbus), one beat at a time.
// dbus has fixed priority; after D_STREAK_MAX back-to-back dbus wins with ibus waiting, ibus goes next.
module mem_bus_arbiter
  import common::*;
  import pipes::*;
#(
  parameter int D_STREAK_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int SW = $clog2(D_STREAK_MAX + 1);

  arb_state_t    state_q, state_d;
  cbus_req_t     req_q, req_d;
  logic [SW-1:0] streak;
  logic          streak_full, done;
  logic          grant_i, grant_d;
  logic          streak_clr, streak_inc;

  assign streak_full = (streak == SW'(D_STREAK_MAX));
  assign done        = oresp.ready && oresp.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Grant decision; a completed transaction always passes through IDLE so the
  // requester sees its handshake before it can be arbitrated again.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid && !(ireq.valid && streak_full)) begin
          state_d = BUSY_D;
          grant_d = 1'b1;
        end else if (ireq.valid) begin
          state_d = BUSY_I;
          grant_i = 1'b1;
        end
      end
      BUSY_I, BUSY_D: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (grant_d)                          req_d = to_cbus_d(dreq);
    else if (grant_i)                     req_d = to_cbus_i(ireq);
    else if ((state_q != IDLE) && done)   req_d = '0;
  end

  assign streak_inc = grant_d && ireq.valid;
  assign streak_clr = grant_i || ((state_q == IDLE) && !ireq.valid);

  streak_counter #(.MAX(D_STREAK_MAX), .W(SW)) u_streak (
    .clk   (clk),
    .reset (reset),
    .clr   (streak_clr),
    .inc   (streak_inc),
    .count (streak)
  );

  // Response demux: only the granted side sees the pulse, and never during reset.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    if (state_q != IDLE) begin
      oreq       = req_q;
      oreq.valid = 1'b1;
    end
    if (!reset && done) begin
      unique case (state_q)
        BUSY_I: begin
          iresp.addr_ok = 1'b1;
          iresp.data_ok = 1'b1;
          iresp.data    = oresp.data;
        end
        BUSY_D: begin
          dresp.addr_ok = 1'b1;
          dresp.data_ok = 1'b1;
          dresp.data    = oresp.data;
        end
        default: ;
      endcase
    end
  end
endmodule
